// File: rtl/sat_penetration_scan.sv
// Separating-axis penetration search: for each face of A, find B's support vertex
// sequentially, evaluate the saturated penetration and keep the greatest one.
module sat_penetration_scan #(
    parameter int NV         = 4,
    parameter int CW         = 19,
    parameter int NW         = 10,
    parameter int FRAC       = 8,
    parameter int EARLY_EXIT = 0,
    localparam int IW        = (NV > 2) ? $clog2(NV) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NV*CW-1:0]     a_x,
    input  logic [NV*CW-1:0]     a_y,
    input  logic [NV*CW-1:0]     b_x,
    input  logic [NV*CW-1:0]     b_y,
    input  logic [CW-1:0]        bpos_x,
    input  logic [CW-1:0]        bpos_y,
    input  logic [NV*NW-1:0]     n_x,
    input  logic [NV*NW-1:0]     n_y,
    output logic                 busy,
    output logic                 done,
    output logic [CW-1:0]        best_pen,
    output logic [NW-1:0]        best_nx,
    output logic [NW-1:0]        best_ny,
    output logic [IW-1:0]        best_idx,
    output logic [IW-1:0]        best_vidx,
    output logic                 separated
);

    localparam int SW = CW + NW + 3;
    localparam logic [IW-1:0]        LAST    = IW'(NV - 1);
    localparam logic signed [CW-1:0] PEN_MIN = {1'b1, {(CW-1){1'b0}}};
    localparam logic signed [CW-1:0] PEN_MAX = {1'b0, {(CW-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, SUPPORT, EVAL, DONE} state_t;

    state_t state_q, state_d;

    logic [NV*CW-1:0]        a_x_q, a_y_q, b_x_q, b_y_q;
    logic signed [CW-1:0]    bpos_x_q, bpos_y_q;
    logic [NV*NW-1:0]        n_x_q, n_y_q;
    logic                    capture_en;

    logic [IW-1:0]           f_q, f_d, j_q, j_d;
    logic signed [CW:0]      sup_wx_q, sup_wx_d, sup_wy_q, sup_wy_d;
    logic signed [SW-1:0]    sup_s_q, sup_s_d;
    logic [IW-1:0]           sup_j_q, sup_j_d;

    logic signed [CW-1:0]    best_pen_q, best_pen_d;
    logic signed [NW-1:0]    best_nx_q, best_nx_d, best_ny_q, best_ny_d;
    logic [IW-1:0]           best_idx_q, best_idx_d, best_vidx_q, best_vidx_d;
    logic                    sep_q, sep_d;

    // Operand selection from the captured polygon data.
    logic signed [CW-1:0]    ax_sel, ay_sel, bx_sel, by_sel;
    logic signed [NW-1:0]    nx_sel, ny_sel;

    assign ax_sel = a_x_q[int'(f_q)*CW +: CW];
    assign ay_sel = a_y_q[int'(f_q)*CW +: CW];
    assign bx_sel = b_x_q[int'(j_q)*CW +: CW];
    assign by_sel = b_y_q[int'(j_q)*CW +: CW];
    assign nx_sel = n_x_q[int'(f_q)*NW +: NW];
    assign ny_sel = n_y_q[int'(f_q)*NW +: NW];

    // Support step: world vertex and its score against the negated normal.
    logic signed [CW:0]      wx_c, wy_c;
    logic signed [SW-1:0]    s_c;

    assign wx_c = {bx_sel[CW-1], bx_sel} + {bpos_x_q[CW-1], bpos_x_q};
    assign wy_c = {by_sel[CW-1], by_sel} + {bpos_y_q[CW-1], bpos_y_q};
    assign s_c  = -((SW'(wx_c) * SW'(nx_sel)) + (SW'(wy_c) * SW'(ny_sel)));

    // Evaluation step: signed distance of the support point, rescaled and clamped.
    logic signed [CW+1:0]    dx_c, dy_c;
    logic signed [SW-1:0]    d_c, pf_c;
    logic [SW-CW:0]          pf_top;
    logic signed [CW-1:0]    p_c;

    assign dx_c   = (CW+2)'(sup_wx_q) - (CW+2)'(ax_sel);
    assign dy_c   = (CW+2)'(sup_wy_q) - (CW+2)'(ay_sel);
    assign d_c    = (SW'(dx_c) * SW'(nx_sel)) + (SW'(dy_c) * SW'(ny_sel));
    assign pf_c   = d_c >>> FRAC;
    assign pf_top = pf_c[SW-1:CW-1];

    always_comb begin
        p_c = pf_c[CW-1:0];
        if (!((&pf_top) || !(|pf_top))) begin
            p_c = pf_c[SW-1] ? PEN_MIN : PEN_MAX;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        capture_en  = 1'b0;
        f_d         = f_q;
        j_d         = j_q;
        sup_wx_d    = sup_wx_q;
        sup_wy_d    = sup_wy_q;
        sup_s_d     = sup_s_q;
        sup_j_d     = sup_j_q;
        best_pen_d  = best_pen_q;
        best_nx_d   = best_nx_q;
        best_ny_d   = best_ny_q;
        best_idx_d  = best_idx_q;
        best_vidx_d = best_vidx_q;
        sep_d       = sep_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    capture_en  = 1'b1;
                    state_d     = SUPPORT;
                    f_d         = '0;
                    j_d         = '0;
                    best_pen_d  = PEN_MIN;
                    best_nx_d   = '0;
                    best_ny_d   = '0;
                    best_idx_d  = '0;
                    best_vidx_d = '0;
                    sep_d       = 1'b0;
                end
            end
            SUPPORT: begin
                if ((j_q == '0) || (s_c > sup_s_q)) begin
                    sup_wx_d = wx_c;
                    sup_wy_d = wy_c;
                    sup_s_d  = s_c;
                    sup_j_d  = j_q;
                end
                if (j_q == LAST) begin
                    state_d = EVAL;
                end else begin
                    j_d = j_q + IW'(1);
                end
            end
            EVAL: begin
                if (p_c > best_pen_q) begin
                    best_pen_d  = p_c;
                    best_nx_d   = nx_sel;
                    best_ny_d   = ny_sel;
                    best_idx_d  = f_q;
                    best_vidx_d = sup_j_q;
                end
                if ((f_q == LAST) || ((EARLY_EXIT != 0) && !p_c[CW-1])) begin
                    state_d = DONE;
                    sep_d   = !best_pen_d[CW-1];
                end else begin
                    state_d = SUPPORT;
                    f_d     = f_q + IW'(1);
                    j_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            best_pen_q  <= PEN_MIN;
            best_nx_q   <= '0;
            best_ny_q   <= '0;
            best_idx_q  <= '0;
            best_vidx_q <= '0;
            sep_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            best_pen_q  <= best_pen_d;
            best_nx_q   <= best_nx_d;
            best_ny_q   <= best_ny_d;
            best_idx_q  <= best_idx_d;
            best_vidx_q <= best_vidx_d;
            sep_q       <= sep_d;
        end
    end

    // NOTE: datapath registers carry no reset; they are always written before being read.
    always_ff @(posedge clk) begin
        if (capture_en) begin
            a_x_q    <= a_x;
            a_y_q    <= a_y;
            b_x_q    <= b_x;
            b_y_q    <= b_y;
            bpos_x_q <= bpos_x;
            bpos_y_q <= bpos_y;
            n_x_q    <= n_x;
            n_y_q    <= n_y;
        end
        f_q      <= f_d;
        j_q      <= j_d;
        sup_wx_q <= sup_wx_d;
        sup_wy_q <= sup_wy_d;
        sup_s_q  <= sup_s_d;
        sup_j_q  <= sup_j_d;
    end

    assign busy      = (state_q == SUPPORT) || (state_q == EVAL);
    assign done      = (state_q == DONE);
    assign best_pen  = best_pen_q;
    assign best_nx   = best_nx_q;
    assign best_ny   = best_ny_q;
    assign best_idx  = best_idx_q;
    assign best_vidx = best_vidx_q;
    assign separated = sep_q;

endmodule

// File: tb/tb_sat_penetration_scan.sv
// Bench for sat_penetration_scan: one instance per EARLY_EXIT setting, fed the same
// stimulus, checked against hand-derived vectors and a behavioural reference model.
module tb_sat_penetration_scan;

    localparam int NV    = 4;
    localparam int CW    = 19;
    localparam int NW    = 10;
    localparam int FRAC  = 8;
    localparam int IW    = 2;
    localparam int MAXK  = NV * (NV + 1) + 4;
    localparam longint PMIN = -(longint'(1) <<< (CW - 1));
    localparam longint PMAX = (longint'(1) <<< (CW - 1)) - 1;

    typedef struct {
        logic [NV-1:0][31:0] ax, ay, bx, by, nx, ny;
        int bpx, bpy;
    } stim_t;

    typedef struct {
        longint pen;
        int idx, vidx, nx, ny, sep, dedge;
    } res_t;

    typedef struct {
        stim_t s;
        res_t  e0;
        res_t  e1;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, start;
    logic [NV*CW-1:0] a_x, a_y, b_x, b_y;
    logic [CW-1:0]    bpos_x, bpos_y;
    logic [NV*NW-1:0] n_x, n_y;

    logic busy0, done0, sep0, busy1, done1, sep1;
    logic signed [CW-1:0] pen0, pen1;
    logic signed [NW-1:0] nx0, ny0, nx1, ny1;
    logic [IW-1:0] idx0, vidx0, idx1, vidx1;

    int total = 0;
    int bad   = 0;

    sat_penetration_scan #(.NV(NV), .CW(CW), .NW(NW), .FRAC(FRAC), .EARLY_EXIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_x(a_x), .a_y(a_y), .b_x(b_x), .b_y(b_y),
        .bpos_x(bpos_x), .bpos_y(bpos_y), .n_x(n_x), .n_y(n_y),
        .busy(busy0), .done(done0), .best_pen(pen0), .best_nx(nx0), .best_ny(ny0),
        .best_idx(idx0), .best_vidx(vidx0), .separated(sep0)
    );

    sat_penetration_scan #(.NV(NV), .CW(CW), .NW(NW), .FRAC(FRAC), .EARLY_EXIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_x(a_x), .a_y(a_y), .b_x(b_x), .b_y(b_y),
        .bpos_x(bpos_x), .bpos_y(bpos_y), .n_x(n_x), .n_y(n_y),
        .busy(busy1), .done(done1), .best_pen(pen1), .best_nx(nx1), .best_ny(ny1),
        .best_idx(idx1), .best_vidx(vidx1), .separated(sep1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sv(input logic [31:0] v);
        return longint'(int'(v));
    endfunction

    function automatic res_t mk_res(input longint pen, input int idx, input int vidx,
                                    input int nx, input int ny, input int sep, input int dedge);
        res_t r;
        r.pen = pen; r.idx = idx; r.vidx = vidx; r.nx = nx; r.ny = ny;
        r.sep = sep; r.dedge = dedge;
        return r;
    endfunction

    function automatic stim_t square(input int bpx, input int bpy);
        stim_t s;
        int ax[4]  = '{0, 1024, 1024, 0};
        int ay[4]  = '{0, 0, 1024, 1024};
        int nxv[4] = '{0, 256, 0, -256};
        int nyv[4] = '{-256, 0, 256, 0};
        int bxv[4] = '{-512, 512, 512, -512};
        int byv[4] = '{-512, -512, 512, 512};
        for (int i = 0; i < NV; i++) begin
            s.ax[i] = ax[i];  s.ay[i] = ay[i];
            s.nx[i] = nxv[i]; s.ny[i] = nyv[i];
            s.bx[i] = bxv[i]; s.by[i] = byv[i];
        end
        s.bpx = bpx;
        s.bpy = bpy;
        return s;
    endfunction

    function automatic int rnd(input int lim);
        return int'($urandom_range(0, 2 * lim - 1)) - lim;
    endfunction

    function automatic stim_t rand_stim(input bit wide);
        stim_t s;
        int lim = wide ? (1 << (CW - 1)) : 2048;
        for (int i = 0; i < NV; i++) begin
            s.ax[i] = rnd(lim); s.ay[i] = rnd(lim);
            s.bx[i] = rnd(lim); s.by[i] = rnd(lim);
            s.nx[i] = rnd(1 << (NW - 1)); s.ny[i] = rnd(1 << (NW - 1));
        end
        s.bpx = rnd(lim);
        s.bpy = rnd(lim);
        return s;
    endfunction

    // Reference: brute-force support search, floor-divide by 2^FRAC, clamp, keep the max.
    function automatic res_t model(input stim_t s, input bit ee);
        res_t   r;
        longint best, bs, wx, wy, sc, swx, swy, d, p, nxf, nyf, scale;
        int     bj, faces;
        scale = longint'(1) <<< FRAC;
        best  = PMIN;
        r     = mk_res(PMIN, 0, 0, 0, 0, 0, 0);
        faces = 0;
        for (int f = 0; f < NV; f++) begin
            nxf = sv(s.nx[f]);
            nyf = sv(s.ny[f]);
            bs = 0; swx = 0; swy = 0; bj = 0;
            for (int j = 0; j < NV; j++) begin
                wx = sv(s.bx[j]) + longint'(s.bpx);
                wy = sv(s.by[j]) + longint'(s.bpy);
                sc = -(wx * nxf + wy * nyf);
                if (j == 0 || sc > bs) begin
                    bs = sc; swx = wx; swy = wy; bj = j;
                end
            end
            d = (swx - sv(s.ax[f])) * nxf + (swy - sv(s.ay[f])) * nyf;
            p = d / scale;
            if (d < 0 && p * scale != d) p = p - 1;
            if (p > PMAX) p = PMAX;
            if (p < PMIN) p = PMIN;
            faces++;
            if (p > best) begin
                best = p;
                r.idx = f; r.vidx = bj; r.nx = int'(nxf); r.ny = int'(nyf);
            end
            if (ee && p >= 0) break;
        end
        r.pen   = best;
        r.sep   = (best >= 0) ? 1 : 0;
        r.dedge = faces * (NV + 1);
        return r;
    endfunction

    task automatic apply(input stim_t s);
        for (int i = 0; i < NV; i++) begin
            a_x[i*CW +: CW] = s.ax[i][CW-1:0];
            a_y[i*CW +: CW] = s.ay[i][CW-1:0];
            b_x[i*CW +: CW] = s.bx[i][CW-1:0];
            b_y[i*CW +: CW] = s.by[i][CW-1:0];
            n_x[i*NW +: NW] = s.nx[i][NW-1:0];
            n_y[i*NW +: NW] = s.ny[i][NW-1:0];
        end
        bpos_x = s.bpx[CW-1:0];
        bpos_y = s.bpy[CW-1:0];
    endtask

    // Start at edge 0 with s, then drive alt; optionally re-pulse start or assert reset at edge k.
    task automatic run(input stim_t s, input stim_t alt, input int repulse_k, input int rst_k,
                       output res_t r0, output res_t r1, output int p0, output int p1);
        r0 = mk_res(0, 0, 0, 0, 0, 0, -1);
        r1 = mk_res(0, 0, 0, 0, 0, 0, -1);
        p0 = 0;
        p1 = 0;
        @(negedge clk);
        apply(s);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        apply(alt);
        for (int k = 1; k <= MAXK; k++) begin
            start = (k == repulse_k);
            rst_n = (k != rst_k);
            @(posedge clk);
            #1;
            start = 1'b0;
            rst_n = 1'b1;
            if (k == rst_k) begin
                check("rst busy0", longint'(busy0), 0);
                check("rst busy1", longint'(busy1), 0);
                check("rst done0", longint'(done0), 0);
                check("rst pen0", longint'(pen0), PMIN);
                check("rst idx0", longint'(idx0), 0);
                check("rst vidx0", longint'(vidx0), 0);
            end
            if (done0) begin
                p0++;
                if (r0.dedge < 0)
                    r0 = mk_res(longint'(pen0), int'(idx0), int'(vidx0), int'(nx0), int'(ny0),
                                int'(sep0), k);
            end
            if (done1) begin
                p1++;
                if (r1.dedge < 0)
                    r1 = mk_res(longint'(pen1), int'(idx1), int'(vidx1), int'(nx1), int'(ny1),
                                int'(sep1), k);
            end
        end
    endtask

    task automatic compare(input string tag, input res_t a, input res_t e, input int pulses);
        check({tag, " done_edge"}, a.dedge, e.dedge);
        check({tag, " pen"}, a.pen, e.pen);
        check({tag, " idx"}, a.idx, e.idx);
        check({tag, " vidx"}, a.vidx, e.vidx);
        check({tag, " nx"}, a.nx, e.nx);
        check({tag, " ny"}, a.ny, e.ny);
        check({tag, " sep"}, a.sep, e.sep);
        check({tag, " pulses"}, pulses, 1);
    endtask

    initial begin
        vec_t  tbl[3];
        stim_t sat, rs;
        res_t  r0, r1, e0, e1;
        int    p0, p1;

        tbl[0].s  = square(1280, 512);
        tbl[0].e0 = mk_res(-256, 1, 0, 256, 0, 0, 20);
        tbl[0].e1 = mk_res(-256, 1, 0, 256, 0, 0, 20);
        tbl[1].s  = square(2560, 512);
        tbl[1].e0 = mk_res(1024, 1, 0, 256, 0, 1, 20);
        tbl[1].e1 = mk_res(1024, 1, 0, 256, 0, 1, 10);
        for (int i = 0; i < NV; i++) begin
            sat.ax[i] = -262144; sat.ay[i] = 0;
            sat.nx[i] = 511;     sat.ny[i] = 0;
            sat.bx[i] = 262143;  sat.by[i] = 0;
        end
        sat.bpx = 0;
        sat.bpy = 0;
        tbl[2].s  = sat;
        tbl[2].e0 = mk_res(262143, 0, 0, 511, 0, 1, 20);
        tbl[2].e1 = mk_res(262143, 0, 0, 511, 0, 1, 5);

        rst_n = 1'b0;
        start = 1'b0;
        apply(tbl[0].s);
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", longint'(busy0), 0);
        check("reset done", longint'(done0), 0);
        check("reset pen", longint'(pen0), PMIN);
        check("reset idx", longint'(idx0), 0);
        check("reset vidx", longint'(vidx0), 0);
        check("reset nx", longint'(nx0), 0);
        check("reset sep", longint'(sep0), 0);
        check("reset pen ee", longint'(pen1), PMIN);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            run(tbl[i].s, rand_stim(1'b1), -1, -1, r0, r1, p0, p1);
            compare($sformatf("tbl%0d ee0", i), r0, tbl[i].e0, p0);
            compare($sformatf("tbl%0d ee1", i), r1, tbl[i].e1, p1);
        end

        for (int i = 0; i < 30; i++) begin
            rs = rand_stim(i % 3 == 2);
            e0 = model(rs, 1'b0);
            e1 = model(rs, 1'b1);
            run(rs, rand_stim(1'b1), -1, -1, r0, r1, p0, p1);
            compare($sformatf("rand%0d ee0", i), r0, e0, p0);
            compare($sformatf("rand%0d ee1", i), r1, e1, p1);
        end

        run(tbl[0].s, tbl[1].s, 7, -1, r0, r1, p0, p1);
        compare("busy_start ee0", r0, tbl[0].e0, p0);
        compare("busy_start ee1", r1, tbl[0].e1, p1);

        run(tbl[0].s, rand_stim(1'b1), -1, 9, r0, r1, p0, p1);
        check("abort pulses0", p0, 0);
        check("abort pulses1", p1, 0);
        run(tbl[0].s, rand_stim(1'b1), -1, -1, r0, r1, p0, p1);
        compare("rerun ee0", r0, tbl[0].e0, p0);
        compare("rerun ee1", r1, tbl[0].e1, p1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
